lane_selector_pipe: RTL and testbench
=====================================

Name: lane_selector_pipe

Overview:
Parametrised lane crossbar. Each output lane takes any LANE_W-bit lane of any of NUM_SRC source words, or zero.
Generalises the fixed two-source, 32-bit selector to N sources, configurable lane width and output lane count.
Adds a valid/ready handshake with a 2-entry output buffer so it sits between pipelined datapath stages without stalling upstream on a one-cycle downstream hiccup.

Parameters:
DATA_W, 32, width of each source word; must be a multiple of LANE_W.
LANE_W, 4, width of one lane in bits.
NUM_SRC, 2, number of source words (≥1).
NUM_OUT, 4, number of output lanes.
Derived: NUM_LANES=DATA_W/LANE_W; LIDX_W=max(1,clog2(NUM_LANES)); SIDX_W=max(1,clog2(NUM_SRC)).

Ports:
CLK  in  1  single clock, all logic on posedge.
RESET_L  in  1  reset; synchronous, active-low.
in_valid  in  1  input transaction present.
in_ready  out  1  block can accept this cycle.
in_data  in  NUM_SRC*DATA_W  source words; source s at [s*DATA_W +: DATA_W].
sel_lane  in  NUM_OUT*LIDX_W  per output lane k, source lane index at [k*LIDX_W +: LIDX_W].
sel_src  in  NUM_OUT*SIDX_W  per output lane k, source index at [k*SIDX_W +: SIDX_W].
lane_en  in  NUM_OUT  per output lane enable; 0 forces that lane to zero.
out_valid  out  1  buffer head valid.
out_ready  in  1  downstream accepts.
out_data  out  NUM_OUT*LANE_W  selected lanes; lane k at [k*LANE_W +: LANE_W].
sel_err  out  1  present only with SEL_RANGE_CHECK_EN (see below).

Behaviour:
- Accept = in_valid & in_ready; pop = out_valid & out_ready.
- Lane k value: lane_en[k] ? in_data source sel_src[k], bits [sel_lane[k]*LANE_W +: LANE_W] : 0.
- Lane k is zero when sel_src[k] ≥ NUM_SRC or sel_lane[k] ≥ NUM_LANES (out of range).
- sel_lane, sel_src and lane_en are sampled together with in_data only on accept; they are don't-care otherwise.
- Buffer: 2-entry FIFO of NUM_OUT*LANE_W words; occupancy count 0..2; separate write and read pointers, each 1 bit, wrapping.
- in_ready = (count != 2). It is combinational from registered state only, with no path from out_ready.
- out_valid = (count != 0); out_data = entry at read pointer, driven from a register.
- Latency: a word accepted at posedge k is visible on out_data with out_valid=1 after posedge k (1 cycle), provided the buffer was empty.
- Ordering is strictly FIFO.
- Accept and pop in the same cycle with count=1: count stays 1, both pointers advance.
- Accept and pop in the same cycle with count=0: impossible, because out_valid=0.
- Pop at count=2: count becomes 1 and in_ready rises the next cycle. The same-cycle accept is blocked because in_ready=0.
- out_data holds stable while out_valid=1 and out_ready=0.
- Reset (RESET_L=0 at posedge), including mid-transfer:
  - count=0, pointers=0, out_valid=0, in_ready=1 after the edge;
  - out_data=0 and all buffer entries=0;
  - sel_err=0;
  - in-flight words are discarded.
- While RESET_L=0, in_valid is ignored.

Optional Feature:
Macro SEL_RANGE_CHECK_EN.
- Defined:
  - Port sel_err exists.
  - sel_err sets on any accept where an enabled lane has sel_src ≥ NUM_SRC or sel_lane ≥ NUM_LANES. It is sticky, visible the cycle after that accept, and cleared only by reset.
  - Data behaviour is unchanged: offending lanes output zero.
- Not defined: no sel_err port and no check logic; out-of-range lanes still output zero.

Test Plan:
1. Reset, defaults, src0=0x00000FFF, src1=0x0000ABCD, all lane_en=1, sel_src=1 for all lanes, sel_lane={3,2,1,0}, out_ready=1 -> out_data=0xABCD one cycle after accept; in_ready stays 1.
2. Same sources, all lanes sel_src=0, sel_lane=1 -> out_data=0xFFFF. Then lane_en=4'b0101 -> out_data=0x0F0F.
3. out_ready=0, send 3 back-to-back words W0,W1,W2:
   - W0 and W1 are accepted; in_ready=0 on the third cycle, so W2 is held.
   - Raise out_ready: outputs W0,W1,W2 in order; count returns to 0; out_data is stable while stalled.
4. count=1 with simultaneous accept and pop for 8 cycles using incrementing patterns -> count stays 1, outputs arrive in order, no bubble.
5. RESET_L=0 for one edge while count=2 -> next cycle out_valid=0, out_data=0, in_ready=1; the next accept appears with 1-cycle latency.
6. NUM_SRC=3, sel_src=3 on enabled lane 2:
   - Lane 2 outputs 0.
   - With SEL_RANGE_CHECK_EN, sel_err=1 the next cycle and stays 1 through further valid traffic until reset.

Source files
------------

// File: rtl/lane_selector_pipe.sv
// ---------------------------------------------------------------------------
// lane_selector_pipe
//
// Parametrised lane crossbar with a 2-entry output buffer.
//
// Every output lane k picks one LANE_W-bit lane out of any of NUM_SRC source
// words, or zero. The lane is zero when it is disabled or when its source or
// lane index is out of range. The selected word goes into a 2-entry FIFO
// behind a valid/ready handshake. Because of this, a one-cycle downstream
// stall does not back-pressure upstream.
//
// Optional feature (compile-time macro):
//   SEL_RANGE_CHECK_EN - adds the sticky sel_err output. It sets on any
//                        accept where an enabled lane selects an
//                        out-of-range source or lane. It clears only on
//                        reset.
//
// Parameters:
//   DATA_W   width of one source word (multiple of LANE_W)
//   LANE_W   width of one lane
//   NUM_SRC  number of source words (>= 1)
//   NUM_OUT  number of output lanes
//
// Ports:
//   CLK        clock, all state on the rising edge
//   RESET_L    synchronous active-low reset
//   in_valid   upstream transaction present
//   in_ready   buffer has room (from registered state only)
//   in_data    NUM_SRC source words, source s at [s*DATA_W +: DATA_W]
//   sel_lane   per output lane source-lane index, [k*LIDX_W +: LIDX_W]
//   sel_src    per output lane source index, [k*SIDX_W +: SIDX_W]
//   lane_en    per output lane enable, 0 forces the lane to zero
//   out_valid  buffer head valid
//   out_ready  downstream accepts the head
//   out_data   buffer head, lane k at [k*LANE_W +: LANE_W]
//   sel_err    sticky range error (only with SEL_RANGE_CHECK_EN)
// ---------------------------------------------------------------------------
module lane_selector_pipe #(
  parameter  int DATA_W    = 32,
  parameter  int LANE_W    = 4,
  parameter  int NUM_SRC   = 2,
  parameter  int NUM_OUT   = 4,
  localparam int NUM_LANES = DATA_W / LANE_W,
  localparam int LIDX_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  localparam int SIDX_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                        CLK,
  input  logic                        RESET_L,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_SRC*DATA_W-1:0]   in_data,
  input  logic [NUM_OUT*LIDX_W-1:0]   sel_lane,
  input  logic [NUM_OUT*SIDX_W-1:0]   sel_src,
  input  logic [NUM_OUT-1:0]          lane_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_OUT*LANE_W-1:0]   out_data
`ifdef SEL_RANGE_CHECK_EN
  ,
  output logic                        sel_err
`endif
);

  typedef logic [NUM_OUT*LANE_W-1:0] word_t;

  // The buffer occupancy is the only control state, so it is the FSM state.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  occ_t  occ_q, occ_d;
  logic  wr_ptr_q, wr_ptr_d;
  logic  rd_ptr_q, rd_ptr_d;
  word_t mem_q [2];
  word_t mem_d [2];
  word_t head_q, head_d;
  word_t sel_word;
  logic  accept;
  logic  pop;

  // -------------------------------------------------------------------------
  // Crossbar: every (source, lane) pair is compared against the request
  // with constant part-selects. An out-of-range index matches no pair and
  // so gives zero without any explicit range test on the data path.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    sel_word = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        for (int l = 0; l < NUM_LANES; l++) begin
          if (lane_en[k] &&
              (sel_src[k*SIDX_W +: SIDX_W]  == SIDX_W'(s)) &&
              (sel_lane[k*LIDX_W +: LIDX_W] == LIDX_W'(l))) begin
            sel_word[k*LANE_W +: LANE_W] = in_data[s*DATA_W + l*LANE_W +: LANE_W];
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Handshake. in_ready depends only on the occupancy register, so there is
  // no combinational path from out_ready back to in_ready.
  // -------------------------------------------------------------------------
  assign in_ready  = (occ_q != OCC_FULL);
  assign out_valid = (occ_q != OCC_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // -------------------------------------------------------------------------
  // Next-state logic for occupancy, pointers, storage and the head register.
  // -------------------------------------------------------------------------
  always_comb begin
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q ^ accept;
    rd_ptr_d = rd_ptr_q ^ pop;
    mem_d    = mem_q;

    unique case (occ_q)
      OCC_EMPTY: if (accept)         occ_d = OCC_ONE;
      OCC_ONE:   if (accept && !pop) occ_d = OCC_FULL;
                 else if (!accept && pop) occ_d = OCC_EMPTY;
      OCC_FULL:  if (pop)            occ_d = OCC_ONE;
      default:                       occ_d = OCC_EMPTY;
    endcase

    if (accept) begin
      mem_d[wr_ptr_q] = sel_word;
    end

    // out_data comes straight from a register. That register is loaded with
    // whatever entry the read pointer will address after this edge. The
    // entry is written only when the buffer is empty, and it is not rewritten
    // while a stalled head is waiting, so out_data holds steady during a stall.
    head_d = mem_d[rd_ptr_d];
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments. Then every
    // register samples the pre-edge values, whatever the statement order.
    if (!RESET_L) begin
      occ_q    <= OCC_EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      // NOTE: the two storage entries are cleared on reset. They are tiny,
      // and after reset the head register and every entry must read zero,
      // so nothing stale can reappear.
      mem_q    <= '{default: '0};
      head_q   <= '0;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
      head_q   <= head_d;
    end
  end

  assign out_data = head_q;

`ifdef SEL_RANGE_CHECK_EN
  // -------------------------------------------------------------------------
  // Sticky range check. Only enabled lanes count. A disabled lane with a
  // garbage index is legitimate and outputs zero anyway.
  // -------------------------------------------------------------------------
  logic range_hit;
  logic sel_err_q;

  always_comb begin
    range_hit = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (lane_en[k] &&
          ((int'(sel_src[k*SIDX_W +: SIDX_W])  >= NUM_SRC) ||
           (int'(sel_lane[k*LIDX_W +: LIDX_W]) >= NUM_LANES))) begin
        range_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      sel_err_q <= 1'b0;
    end else if (accept && range_hit) begin
      sel_err_q <= 1'b1;
    end
  end

  assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_lane_selector_pipe.sv
// ---------------------------------------------------------------------------
// tb_lane_selector_pipe
//
// Self-checking bench for lane_selector_pipe. It uses NUM_SRC=3 so that an
// out-of-range source index (3) can be expressed. A reference model computes
// each expected word when it is accepted and pushes it to a queue. A monitor
// pops and compares the queue whenever the DUT hands a word downstream.
// Directed checks cover reset, latency, stall stability and handshake
// boundaries.
// ---------------------------------------------------------------------------
module tb_lane_selector_pipe;

  localparam int DATA_W    = 32;
  localparam int LANE_W    = 4;
  localparam int NUM_SRC   = 3;
  localparam int NUM_OUT   = 4;
  localparam int NUM_LANES = DATA_W / LANE_W;
  localparam int LIDX_W    = 3;
  localparam int SIDX_W    = 2;
  localparam int OW        = NUM_OUT * LANE_W;
  localparam int IW        = NUM_SRC * DATA_W;

  logic                      CLK = 1'b0;
  logic                      RESET_L;
  logic                      in_valid;
  logic                      in_ready;
  logic [IW-1:0]             in_data;
  logic [NUM_OUT*LIDX_W-1:0] sel_lane;
  logic [NUM_OUT*SIDX_W-1:0] sel_src;
  logic [NUM_OUT-1:0]        lane_en;
  logic                      out_valid;
  logic                      out_ready;
  logic [OW-1:0]             out_data;
`ifdef SEL_RANGE_CHECK_EN
  logic                      sel_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [OW-1:0] sb_q [$];

  always #5 CLK = ~CLK;

  lane_selector_pipe #(
    .DATA_W  (DATA_W),
    .LANE_W  (LANE_W),
    .NUM_SRC (NUM_SRC),
    .NUM_OUT (NUM_OUT)
  ) dut (
    .CLK       (CLK),
    .RESET_L   (RESET_L),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sel_lane  (sel_lane),
    .sel_src   (sel_src),
    .lane_en   (lane_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SEL_RANGE_CHECK_EN
    ,
    .sel_err   (sel_err)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model, written directly from the lane-selection rule.
  function automatic logic [OW-1:0] model(input logic [IW-1:0] d,
                                          input logic [NUM_OUT*LIDX_W-1:0] sl,
                                          input logic [NUM_OUT*SIDX_W-1:0] ss,
                                          input logic [NUM_OUT-1:0] en);
    logic [OW-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      int s;
      int l;
      s = int'(ss[k*SIDX_W +: SIDX_W]);
      l = int'(sl[k*LIDX_W +: LIDX_W]);
      if (en[k] && s < NUM_SRC && l < NUM_LANES) begin
        r[k*LANE_W +: LANE_W] = d[s*DATA_W + l*LANE_W +: LANE_W];
      end
    end
    return r;
  endfunction

  function automatic logic [NUM_OUT*LIDX_W-1:0] pack_lane(input int l3, input int l2,
                                                          input int l1, input int l0);
    return {LIDX_W'(l3), LIDX_W'(l2), LIDX_W'(l1), LIDX_W'(l0)};
  endfunction

  function automatic logic [NUM_OUT*SIDX_W-1:0] pack_src(input int s3, input int s2,
                                                         input int s1, input int s0);
    return {SIDX_W'(s3), SIDX_W'(s2), SIDX_W'(s1), SIDX_W'(s0)};
  endfunction

  // Scoreboard monitor. Inputs and outputs are settled at the falling edge,
  // so the handshake seen here is the one the next rising edge performs.
  always @(negedge CLK) begin
    if (!RESET_L) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("sb_unexpected_pop", 0, 1);
        else                  check("sb_data", out_data, sb_q.pop_front());
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(in_data, sel_lane, sel_src, lane_en));
      end
    end
  end

  // Hold the current inputs with in_valid=1 until the DUT accepts them.
  // The task returns 1 time unit after the accepting edge.
  task automatic wait_accept();
    bit ok = 1'b0;
    int n  = 0;
    while (!ok && n < 20) begin
      @(negedge CLK);
      ok = (in_ready === 1'b1);
      @(posedge CLK);
      #1;
      n++;
    end
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic send(input logic [IW-1:0] d, input logic [NUM_OUT*LIDX_W-1:0] sl,
                      input logic [NUM_OUT*SIDX_W-1:0] ss, input logic [NUM_OUT-1:0] en);
    in_data  = d;
    sel_lane = sl;
    sel_src  = ss;
    lane_en  = en;
    in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
  endtask

  // Random in-range stimulus; exp returns the model value for it.
  task automatic set_rand(output logic [OW-1:0] exp);
    in_data = {$urandom, $urandom, $urandom};
    for (int k = 0; k < NUM_OUT; k++) begin
      sel_lane[k*LIDX_W +: LIDX_W] = LIDX_W'($urandom_range(0, NUM_LANES - 1));
      sel_src[k*SIDX_W +: SIDX_W]  = SIDX_W'($urandom_range(0, NUM_SRC - 1));
    end
    lane_en  = NUM_OUT'($urandom);
    in_valid = 1'b1;
    exp      = model(in_data, sel_lane, sel_src, lane_en);
  endtask

  task automatic send_rand(output logic [OW-1:0] exp);
    set_rand(exp);
    wait_accept();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (out_valid && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("drain_empty", out_valid, 0);
  endtask

  task automatic apply_reset();
    RESET_L = 1'b0;
    @(posedge CLK);
    #1;
    RESET_L = 1'b1;
  endtask

  initial begin
    logic [OW-1:0] w0, w1, w2, e;
    logic [IW-1:0] srcs;

    RESET_L   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    sel_lane  = '0;
    sel_src   = '0;
    lane_en   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RESET_L = 1'b1;

    // 1. Reset state, then source 1 lanes 3..0 straight through.
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
`ifdef SEL_RANGE_CHECK_EN
    check("rst_sel_err", sel_err, 0);
`endif
    srcs = {32'h0000_0000, 32'h0000_ABCD, 32'h0000_0FFF};
    send(srcs, pack_lane(3, 2, 1, 0), pack_src(1, 1, 1, 1), 4'hF);
    check("t1_data", out_data, 16'hABCD);
    check("t1_valid", out_valid, 1);
    check("t1_in_ready", in_ready, 1);

    // 2. Lane 1 of source 0 broadcast, then half the lanes disabled.
    send(srcs, pack_lane(1, 1, 1, 1), pack_src(0, 0, 0, 0), 4'hF);
    check("t2_bcast", out_data, 16'hFFFF);
    send(srcs, pack_lane(1, 1, 1, 1), pack_src(0, 0, 0, 0), 4'b0101);
    check("t2_lane_en", out_data, 16'h0F0F);
    drain();

    // 3. Fill the buffer under stall; the third word must wait.
    out_ready = 1'b0;
    send_rand(w0);
    send_rand(w1);
    set_rand(w2);
    check("t3_full_ready", in_ready, 0);
    repeat (3) begin
      @(posedge CLK);
      #1;
      check("t3_stall_data", out_data, w0);
      check("t3_stall_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    drain();
    check("t3_ready_after", in_ready, 1);

    // 4. Occupancy one with accept and pop together for 8 cycles.
    out_ready = 1'b0;
    send_rand(e);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data  = {3{32'h0123_4567 + 32'(i) * 32'h1111_1111}};
      sel_lane = pack_lane(i % 8, (i + 1) % 8, (i + 2) % 8, (i + 3) % 8);
      sel_src  = pack_src(i % 3, (i + 1) % 3, (i + 2) % 3, 0);
      lane_en  = 4'hF;
      in_valid = 1'b1;
      @(negedge CLK);
      check("t4_in_ready", in_ready, 1);
      check("t4_out_valid", out_valid, 1);
      @(posedge CLK);
      #1;
    end
    in_valid = 1'b0;
    drain();

    // 5. Reset with the buffer full; in_valid high during reset is ignored.
    out_ready = 1'b0;
    send_rand(e);
    send_rand(e);
    set_rand(e);
    apply_reset();
    in_valid = 1'b0;
    check("t5_out_valid", out_valid, 0);
    check("t5_out_data", out_data, 0);
    check("t5_in_ready", in_ready, 1);
    out_ready = 1'b1;
    send_rand(e);
    check("t5_latency_data", out_data, e);
    check("t5_latency_valid", out_valid, 1);
    drain();

    // 6. Out-of-range source on lane 2: first disabled, then enabled.
    srcs = {$urandom, $urandom, $urandom};
    send(srcs, pack_lane(7, 5, 3, 1), pack_src(0, 3, 1, 2), 4'b1011);
`ifdef SEL_RANGE_CHECK_EN
    check("t6_err_disabled", sel_err, 0);
`endif
    send(srcs, pack_lane(7, 5, 3, 1), pack_src(0, 3, 1, 2), 4'hF);
    check("t6_lane2_zero", out_data[11:8], 4'h0);
    check("t6_data", out_data, model(srcs, pack_lane(7, 5, 3, 1), pack_src(0, 3, 1, 2), 4'hF));
`ifdef SEL_RANGE_CHECK_EN
    check("t6_err_set", sel_err, 1);
`endif
    for (int i = 0; i < 3; i++) begin
      send_rand(e);
`ifdef SEL_RANGE_CHECK_EN
      check("t6_err_sticky", sel_err, 1);
`endif
    end
    drain();
    apply_reset();
`ifdef SEL_RANGE_CHECK_EN
    check("t6_err_cleared", sel_err, 0);
`endif
    check("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
